writeback_address_tracker: RTL

//  Write-side companion of the NTT/INTT/PWM read address generator. Captures each

---
 rtl/writeback_address_tracker.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/writeback_address_tracker.sv
// -----------------------------------------------------------------------------
// writeback_address_tracker
//
// Write-side companion of the NTT/INTT/PWM read address generator. Each read
// address quad issued into the butterfly pipeline is captured in a circular
// buffer. One quad is popped per result beat and replayed one cycle later as
// the write-back address set with a write strobe. A pass finishes with a
// one-cycle done pulse after every issued quad has been written back.
//
// Ports
//   clk, rstn                 rising-edge clock, asynchronous active-low reset
//   start                     1-cycle pulse, arms a new pass (only in IDLE)
//   issue_valid, issue_last   read quad issued / final quad of the pass
//   issue_addr_0..3           issued read address quad
//   wb_valid                  butterfly result beat available
//   wr_address_0..3, wen      write-back address quad and its strobe
//   done_flag                 1-cycle pulse, pass fully written back
//   busy                      high while in RUN or DRAIN
//   occupancy                 entries currently held (0..DEPTH)
//   err                       sticky {underflow, overflow}
// -----------------------------------------------------------------------------
module writeback_address_tracker #(
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              issue_valid,
    input  logic              issue_last,
    input  logic [ADDR_W-1:0] issue_addr_0,
    input  logic [ADDR_W-1:0] issue_addr_1,
    input  logic [ADDR_W-1:0] issue_addr_2,
    input  logic [ADDR_W-1:0] issue_addr_3,
    input  logic              wb_valid,
    output logic [ADDR_W-1:0] wr_address_0,
    output logic [ADDR_W-1:0] wr_address_1,
    output logic [ADDR_W-1:0] wr_address_2,
    output logic [ADDR_W-1:0] wr_address_3,
    output logic              wen,
    output logic              done_flag,
    output logic              busy,
    output logic [PTR_W:0]    occupancy,
    output logic [1:0]        err
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [PTR_W:0] OCC_FULL = (PTR_W+1)'(DEPTH);

    state_t                state_q, state_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        occ_q, occ_d;
    logic [1:0]            err_q, err_d;
    logic                  wen_q, wen_d;
    logic                  done_q, done_d;
    logic [4*ADDR_W-1:0]   quad_q, quad_d;

    logic [4*ADDR_W-1:0]   buf_mem [DEPTH];

    logic in_run, in_active, full, empty, pop, push;

    always_comb begin
        in_run    = (state_q == S_RUN);
        in_active = (state_q == S_RUN) || (state_q == S_DRAIN);
        full      = (occ_q == OCC_FULL);
        empty     = (occ_q == '0);
        pop       = wb_valid && in_active && !empty;
        // A full buffer still accepts a push when a pop frees a slot this cycle.
        push      = issue_valid && in_run && (!full || pop);
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        err_d    = err_q;
        wen_d    = pop;
        quad_d   = pop ? buf_mem[rd_ptr_q] : quad_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase

        if (issue_valid && in_run && full && !pop) err_d[0] = 1'b1;
        if (wb_valid && in_active && empty)        err_d[1] = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    occ_d    = '0;
                    err_d    = '0;
                end
            end
            S_RUN: begin
                if (issue_valid && issue_last) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // occupancy reaches 0 in the cycle the final wen is presented,
                // so DONE (and done_flag) lands one cycle after that wen.
                if (empty) state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            err_q    <= '0;
            wen_q    <= 1'b0;
            done_q   <= 1'b0;
            quad_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            err_q    <= err_d;
            wen_q    <= wen_d;
            done_q   <= done_d;
            quad_q   <= quad_d;
        end
    end

    // Buffer storage carries data only; stale entries are never read because
    // occupancy gates every pop.
    always_ff @(posedge clk) begin
        if (push) buf_mem[wr_ptr_q] <= {issue_addr_3, issue_addr_2, issue_addr_1, issue_addr_0};
    end

    assign wr_address_0 = quad_q[ADDR_W-1:0];
    assign wr_address_1 = quad_q[2*ADDR_W-1:ADDR_W];
    assign wr_address_2 = quad_q[3*ADDR_W-1:2*ADDR_W];
    assign wr_address_3 = quad_q[4*ADDR_W-1:3*ADDR_W];
    assign wen          = wen_q;
    assign done_flag    = done_q;
    assign busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign occupancy    = occ_q;
    assign err          = err_q;

endmodule
